// File: rtl/mini_src_exec_ctrl_if.sv
// Strobe and handshake bundle between the Mini SRC control sequencer and its datapath.
interface mini_src_exec_ctrl_if #(
  parameter int IR_W = 32,
  parameter int NREG = 16
);
  logic            run;
  logic            mem_ready;
  logic [IR_W-1:0] IR;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic            MDRin, MDRout, IRin, Yin, HIin, LOin, Cout;
  logic [12:0]     alu_sel;
  logic            done;
  logic            err;
  logic [3:0]      state_dbg;

  modport master (
    input  run, mem_ready, IR,
    output Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
           MDRin, MDRout, IRin, Yin, HIin, LOin, Cout, alu_sel, done, err, state_dbg
  );

  modport slave (
    output run, mem_ready, IR,
    input  Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
           MDRin, MDRout, IRin, Yin, HIin, LOin, Cout, alu_sel, done, err, state_dbg
  );
endinterface

// File: rtl/mini_src_exec_ctrl.sv
// Mini SRC fetch/execute sequencer: strobes decode from state + IR; 5-7 cycles per instruction, stalls in T1 on mem_ready.
// Defining MINI_SRC_IMM_EN adds the addi/andi/ori immediate ops (constant driven onto the bus via Cout).
module mini_src_exec_ctrl #(
  parameter int IR_W            = 32,
  parameter int NREG            = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic                  clock,
  input logic                  clear,
  mini_src_exec_ctrl_if.master ctl
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  state_e state_q, state_d, restart_st;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        is_3op, is_md, is_un, is_imm, illegal;
  logic [12:0] alu_op;

  assign op = ctl.IR[IR_W-1  -: 5];
  assign ra = ctl.IR[IR_W-6  -: 4];
  assign rb = ctl.IR[IR_W-10 -: 4];
  assign rc = ctl.IR[IR_W-14 -: 4];

  assign is_3op = (op <= 5'd8);
  assign is_md  = (op == 5'd12) || (op == 5'd13);
  assign is_un  = (op == 5'd14) || (op == 5'd15);
`ifdef MINI_SRC_IMM_EN
  assign is_imm = (op >= 5'd9) && (op <= 5'd11);
`else
  assign is_imm = 1'b0;
`endif
  assign illegal = !(is_3op || is_md || is_un || is_imm);

  // After the done step run alone decides between back-to-back fetch and IDLE.
  assign restart_st = ctl.run ? S_T0 : S_IDLE;

  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    reg_sel      = '0;
    reg_sel[idx] = 1'b1;
  endfunction

  // alu_sel bit 12 is ADD, walking down to DIV at bit 0.
  always_comb begin
    alu_op = '0;
    case (op)
      5'd12:   alu_op = 13'h0001;
      5'd13:   alu_op = 13'h0002;
      5'd14:   alu_op = 13'h0008;
      5'd15:   alu_op = 13'h0004;
`ifdef MINI_SRC_IMM_EN
      5'd9:    alu_op = 13'h1000;
      5'd10:   alu_op = 13'h0400;
      5'd11:   alu_op = 13'h0200;
`endif
      default: if (is_3op) alu_op = 13'h1000 >> op;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ctl.Rin       = '0;
    ctl.Rout      = '0;
    ctl.PCout     = 1'b0;
    ctl.MARin     = 1'b0;
    ctl.IncPC     = 1'b0;
    ctl.Zin       = 1'b0;
    ctl.Zlowout   = 1'b0;
    ctl.Zhighout  = 1'b0;
    ctl.PCin      = 1'b0;
    ctl.Read      = 1'b0;
    ctl.MDRin     = 1'b0;
    ctl.MDRout    = 1'b0;
    ctl.IRin      = 1'b0;
    ctl.Yin       = 1'b0;
    ctl.HIin      = 1'b0;
    ctl.LOin      = 1'b0;
    ctl.Cout      = 1'b0;
    ctl.alu_sel   = '0;
    ctl.done      = 1'b0;
    ctl.err       = 1'b0;
    ctl.state_dbg = state_q;
    case (state_q)
      S_IDLE: if (ctl.run) state_d = S_T0;
      S_T0: begin
        ctl.PCout = 1'b1;
        ctl.MARin = 1'b1;
        ctl.IncPC = 1'b1;
        ctl.Zin   = 1'b1;
        state_d   = S_T1;
      end
      S_T1: begin
        ctl.Zlowout = 1'b1;
        ctl.PCin    = 1'b1;
        ctl.Read    = 1'b1;
        ctl.MDRin   = 1'b1;
        if (ctl.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        ctl.MDRout = 1'b1;
        ctl.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        if (illegal) begin
          ctl.err = 1'b1;
          state_d = HALT_ON_ILLEGAL ? S_HALT : S_IDLE;
        end else if (is_un) begin
          ctl.Rout    = reg_sel(rb);
          ctl.alu_sel = alu_op;
          ctl.Zin     = 1'b1;
          state_d     = S_T4;
        end else begin
          ctl.Rout = reg_sel(is_md ? ra : rb);
          ctl.Yin  = 1'b1;
          state_d  = S_T4;
        end
      end
      S_T4: begin
        if (is_un) begin
          ctl.Zlowout = 1'b1;
          ctl.Rin     = reg_sel(ra);
          ctl.done    = 1'b1;
          state_d     = restart_st;
        end else begin
          ctl.alu_sel = alu_op;
          ctl.Zin     = 1'b1;
          if (is_imm) ctl.Cout = 1'b1;
          else        ctl.Rout = reg_sel(is_md ? rb : rc);
          state_d = S_T5;
        end
      end
      S_T5: begin
        ctl.Zlowout = 1'b1;
        if (is_md) begin
          ctl.LOin = 1'b1;
          state_d  = S_T6;
        end else begin
          ctl.Rin  = reg_sel(ra);
          ctl.done = 1'b1;
          state_d  = restart_st;
        end
      end
      S_T6: begin
        ctl.Zhighout = 1'b1;
        ctl.HIin     = 1'b1;
        ctl.done     = 1'b1;
        state_d      = restart_st;
      end
      S_HALT: ctl.err = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

endmodule
